// File: rtl/divisor_seq_nb.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, optional two's-complement mode,
// remainder output, divide-by-zero / overflow flags and an init/busy/done handshake.
module divisor_seq_nb #(
  parameter int WIDTH  = 3,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [WIDTH-1:0] Divend,
  input  logic [WIDTH-1:0] Divder,
  output logic [WIDTH-1:0] ResultD,
  output logic [WIDTH-1:0] Resid,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             ovf
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   acum;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] dvnd_raw;
  logic [CW-1:0]    counter;
  logic             sign_q;
  logic             sign_r;
  logic             pend_zero;
  logic             pend_ovf;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // Operand conditioning at the accept edge: magnitudes plus the special cases that bypass iteration.
  logic             dend_neg;
  logic             dder_neg;
  logic [WIDTH-1:0] dend_mag;
  logic [WIDTH-1:0] dder_mag;
  logic             is_zero;
  logic             is_ovf;

  assign dend_neg = SIGNED && Divend[WIDTH-1];
  assign dder_neg = SIGNED && Divder[WIDTH-1];
  assign dend_mag = dend_neg ? neg(Divend) : Divend;
  assign dder_mag = dder_neg ? neg(Divder) : Divder;
  assign is_zero  = (Divder == '0);
  assign is_ovf   = SIGNED && (Divend == MIN_VAL) && (Divder == '1);

  // One restoring step: shift the dividend MSB into the partial remainder, subtract if it fits.
  logic [WIDTH+1:0] acum_sh;
  logic             fits;
  logic [WIDTH:0]   acum_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] r_final;
  logic             last_step;

  assign acum_sh   = {acum, quo[WIDTH-1]};
  assign fits      = (acum_sh >= (WIDTH+2)'(dvsr));
  assign acum_next = (WIDTH+1)'(fits ? acum_sh - (WIDTH+2)'(dvsr) : acum_sh);
  assign quo_next  = {quo[WIDTH-2:0], fits};
  assign last_step = (counter == CW'(1));
  assign q_final   = sign_q ? neg(quo_next) : quo_next;
  assign r_final   = sign_r ? neg(WIDTH'(acum_next)) : WIDTH'(acum_next);

  // NOTE: every register below uses non-blocking assignment so all flops sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (init) state_next = RUN;
      RUN:     if (pend_zero || pend_ovf || last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acum      <= '0;
      quo       <= '0;
      dvsr      <= '0;
      dvnd_raw  <= '0;
      counter   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      pend_zero <= 1'b0;
      pend_ovf  <= 1'b0;
      ResultD   <= '0;
      Resid     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (init) begin
            busy      <= 1'b1;
            quo       <= dend_mag;
            dvsr      <= dder_mag;
            dvnd_raw  <= Divend;
            acum      <= '0;
            counter   <= CW'(WIDTH);
            sign_q    <= dend_neg ^ dder_neg;
            sign_r    <= dend_neg;
            pend_zero <= is_zero;
            pend_ovf  <= is_ovf;
          end
        end
        RUN: begin
          if (pend_zero) begin
            ResultD  <= '1;
            Resid    <= dvnd_raw;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
            done     <= 1'b1;
          end else if (pend_ovf) begin
            ResultD  <= MIN_VAL;
            Resid    <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b1;
            done     <= 1'b1;
          end else begin
            acum    <= acum_next;
            quo     <= quo_next;
            counter <= counter - CW'(1);
            // Visible results change only here, so they stay stable for the whole RUN phase.
            if (last_step) begin
              ResultD  <= q_final;
              Resid    <= r_final;
              div_zero <= 1'b0;
              ovf      <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_seq_nb.sv
// Bench for divisor_seq_nb: four configurations share one operand bus and are all checked against
// an arithmetic reference model; table vectors, hand-written handshake sequences, random and exhaustive runs.
module tb_divisor_seq_nb;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [7:0] a_bus;
  logic [7:0] b_bus;

  always #5 clk = ~clk;

  wire [2:0] q0, r0;
  wire [7:0] q1, r1;
  wire [3:0] q2, r2;
  wire [7:0] q3, r3;
  wire [3:0] busy_v, done_v, z_v, o_v;

  localparam int W_OF  [4] = '{3, 8, 4, 8};
  localparam bit SG_OF [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  divisor_seq_nb #(.WIDTH(3), .SIGNED(1'b0)) u_w3u (
    .clk(clk), .reset(reset), .init(init), .Divend(a_bus[2:0]), .Divder(b_bus[2:0]),
    .ResultD(q0), .Resid(r0), .busy(busy_v[0]), .done(done_v[0]), .div_zero(z_v[0]), .ovf(o_v[0]));
  divisor_seq_nb #(.WIDTH(8), .SIGNED(1'b1)) u_w8s (
    .clk(clk), .reset(reset), .init(init), .Divend(a_bus), .Divder(b_bus),
    .ResultD(q1), .Resid(r1), .busy(busy_v[1]), .done(done_v[1]), .div_zero(z_v[1]), .ovf(o_v[1]));
  divisor_seq_nb #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
    .clk(clk), .reset(reset), .init(init), .Divend(a_bus[3:0]), .Divder(b_bus[3:0]),
    .ResultD(q2), .Resid(r2), .busy(busy_v[2]), .done(done_v[2]), .div_zero(z_v[2]), .ovf(o_v[2]));
  divisor_seq_nb #(.WIDTH(8), .SIGNED(1'b0)) u_w8u (
    .clk(clk), .reset(reset), .init(init), .Divend(a_bus), .Divder(b_bus),
    .ResultD(q3), .Resid(r3), .busy(busy_v[3]), .done(done_v[3]), .div_zero(z_v[3]), .ovf(o_v[3]));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] last_q [4];
  logic [7:0] last_r [4];
  logic       last_z [4];
  logic       last_o [4];

  typedef struct {
    int         inst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    logic       o;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_q(input int i);
    case (i)
      0:       return {5'b0, q0};
      1:       return q1;
      2:       return {4'b0, q2};
      default: return q3;
    endcase
  endfunction

  function automatic logic [7:0] get_r(input int i);
    case (i)
      0:       return {5'b0, r0};
      1:       return r1;
      2:       return {4'b0, r2};
      default: return r3;
    endcase
  endfunction

  // Reference: plain integer division (truncating toward zero) on the operands seen by a w-bit divider.
  function automatic void model(input int w, input bit sg, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z, output logic o);
    int mask, av, bv, qi, ri;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    z    = 1'b0;
    o    = 1'b0;
    if (sg) begin
      if (av >= (1 << (w - 1))) av -= (1 << w);
      if (bv >= (1 << (w - 1))) bv -= (1 << w);
    end
    if (bv == 0) begin
      z  = 1'b1;
      qi = mask;
      ri = av;
    end else if (sg && av == -(1 << (w - 1)) && bv == -1) begin
      o  = 1'b1;
      qi = 1 << (w - 1);
      ri = 0;
    end else begin
      qi = av / bv;
      ri = av % bv;
    end
    q = 8'(qi & mask);
    r = 8'(ri & mask);
  endfunction

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s i%0d ResultD", tag, i), 32'(get_q(i)), 32'd0);
      check($sformatf("%s i%0d Resid", tag, i), 32'(get_r(i)), 32'd0);
      check($sformatf("%s i%0d busy", tag, i), 32'(busy_v[i]), 32'd0);
      check($sformatf("%s i%0d done", tag, i), 32'(done_v[i]), 32'd0);
      check($sformatf("%s i%0d div_zero", tag, i), 32'(z_v[i]), 32'd0);
      check($sformatf("%s i%0d ovf", tag, i), 32'(o_v[i]), 32'd0);
    end
  endtask

  // One init pulse, then watch every instance for 11 edges: latency, single done, busy, held outputs, values.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] eq [4], er [4], pq [4], gq [4], gr [4];
    logic       ez [4], eo [4], gz [4], go [4];
    int         elat [4], lat [4], dcnt [4];
    string      tag;
    for (int i = 0; i < 4; i++) begin
      model(W_OF[i], SG_OF[i], a, b, eq[i], er[i], ez[i], eo[i]);
      elat[i] = (ez[i] || eo[i]) ? 1 : W_OF[i];
      lat[i]  = 0;
      dcnt[i] = 0;
      pq[i]   = get_q(i);
      gq[i]   = '0;
      gr[i]   = '0;
      gz[i]   = 1'b0;
      go[i]   = 1'b0;
    end
    a_bus = a;
    b_bus = b;
    init  = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        tag = $sformatf("i%0d %02h/%02h", i, a, b);
        if (done_v[i]) begin
          dcnt[i]++;
          if (lat[i] == 0) begin
            lat[i] = k;
            gq[i]  = get_q(i);
            gr[i]  = get_r(i);
            gz[i]  = z_v[i];
            go[i]  = o_v[i];
          end
        end
        if (k == 1 && elat[i] > 1) check({tag, " held ResultD"}, 32'(get_q(i)), 32'(pq[i]));
        if (k == elat[i])          check({tag, " busy at done"}, 32'(busy_v[i]), 32'd1);
        if (k == elat[i] + 1)      check({tag, " busy after"}, 32'(busy_v[i]), 32'd0);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("i%0d %02h/%02h", i, a, b);
      check({tag, " latency"}, 32'(lat[i]), 32'(elat[i]));
      check({tag, " done count"}, 32'(dcnt[i]), 32'd1);
      check({tag, " ResultD"}, 32'(gq[i]), 32'(eq[i]));
      check({tag, " Resid"}, 32'(gr[i]), 32'(er[i]));
      check({tag, " div_zero"}, 32'(gz[i]), 32'(ez[i]));
      check({tag, " ovf"}, 32'(go[i]), 32'(eo[i]));
      last_q[i] = gq[i];
      last_r[i] = gr[i];
      last_z[i] = gz[i];
      last_o[i] = go[i];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int         dn, c1, c2;
    logic [7:0] sq1, sr1, sq2, sr2;
    logic [31:0] t;

    tbl[0]  = '{0, 8'h07, 8'h02, 8'h03, 8'h01, 1'b0, 1'b0};
    tbl[1]  = '{0, 8'h05, 8'h00, 8'h07, 8'h05, 1'b1, 1'b0};
    tbl[2]  = '{1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0};
    tbl[3]  = '{1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{3, 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 1'b0};
    tbl[5]  = '{1, 8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
    tbl[6]  = '{1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0};
    tbl[7]  = '{2, 8'h03, 8'h05, 8'h00, 8'h03, 1'b0, 1'b0};
    tbl[8]  = '{2, 8'h0F, 8'h00, 8'h0F, 8'h0F, 1'b1, 1'b0};
    tbl[9]  = '{1, 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 1'b0};
    tbl[10] = '{0, 8'h06, 8'h07, 8'h00, 8'h06, 1'b0, 1'b0};
    tbl[11] = '{3, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};

    reset = 1'b1;
    init  = 1'b0;
    a_bus = '0;
    b_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 12; v++) begin
      do_op(tbl[v].a, tbl[v].b);
      check($sformatf("tbl%0d ResultD", v), 32'(last_q[tbl[v].inst]), 32'(tbl[v].q));
      check($sformatf("tbl%0d Resid", v), 32'(last_r[tbl[v].inst]), 32'(tbl[v].r));
      check($sformatf("tbl%0d div_zero", v), 32'(last_z[tbl[v].inst]), 32'(tbl[v].z));
      check($sformatf("tbl%0d ovf", v), 32'(last_o[tbl[v].inst]), 32'(tbl[v].o));
    end

    // Reset during the 4th RUN cycle of 200/7 aborts with no done pulse.
    a_bus = 8'd200;
    b_bus = 8'd7;
    init  = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("abort");
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done_v[3] || done_v[2]) dn++;
    end
    check("abort no done", 32'(dn), 32'd0);
    do_op(8'd200, 8'd7);
    check("rerun 200/7 q", 32'(last_q[3]), 32'd28);
    check("rerun 200/7 r", 32'(last_r[3]), 32'd4);

    // init held high: ops every 10 cycles on the 8-bit divider, operands changed mid-RUN.
    a_bus = 8'd250;
    b_bus = 8'd9;
    init  = 1'b1;
    dn = 0; c1 = 0; c2 = 0;
    sq1 = '0; sr1 = '0; sq2 = '0; sr2 = '0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        a_bus = 8'd100;
        b_bus = 8'd3;
      end
      if (k == 19) init = 1'b0;
      if (done_v[3]) begin
        dn++;
        if (dn == 1) begin c1 = k; sq1 = q3; sr1 = r3; end
        if (dn == 2) begin c2 = k; sq2 = q3; sr2 = r3; end
      end
    end
    check("held done count", 32'(dn), 32'd2);
    check("held first edge", 32'(c1), 32'd8);
    check("held second edge", 32'(c2), 32'd18);
    check("held 250/9 q", 32'(sq1), 32'd27);
    check("held 250/9 r", 32'(sr1), 32'd7);
    check("held 100/3 q", 32'(sq2), 32'd33);
    check("held 100/3 r", 32'(sr2), 32'd1);

    // An init pulse in mid-RUN is ignored, not queued.
    a_bus = 8'd200;
    b_bus = 8'd7;
    init  = 1'b1;
    dn = 0; c1 = 0; sq1 = '0; sr1 = '0;
    @(posedge clk);
    #1;
    init = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) begin
        init  = 1'b1;
        a_bus = 8'd5;
        b_bus = 8'd1;
      end
      if (k == 4) init = 1'b0;
      if (k == 10) check("pulse busy idle", 32'(busy_v[3]), 32'd0);
      if (done_v[3]) begin
        dn++;
        c1 = k; sq1 = q3; sr1 = r3;
      end
    end
    check("pulse done count", 32'(dn), 32'd1);
    check("pulse done edge", 32'(c1), 32'd8);
    check("pulse q", 32'(sq1), 32'd28);
    check("pulse r", 32'(sr1), 32'd4);

    for (int n = 0; n < 150; n++) begin
      t = $urandom;
      a_bus = t[7:0];
      b_bus = t[15:8];
      if (t[18:16] == 3'd0) b_bus = 8'h00;
      if (t[18:16] == 3'd1) begin
        a_bus = 8'h80;
        b_bus = 8'hFF;
      end
      do_op(a_bus, b_bus);
    end

    // Exhaustive over the 4-bit divider's operand space; other bits random.
    for (int n = 0; n < 256; n++) begin
      t = $urandom;
      do_op({t[7:4], 4'(n >> 4)}, {t[11:8], 4'(n & 15)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
